// File: rtl/rs232_tx_arbiter_if.sv
// Handshake bundle between byte producers, the arbiter and the RS232 transmitter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface rs232_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ack;
   logic [NUM_REQ-1:0]            req_done;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_start;
   logic                          tx_busy;
   logic                          tx_all_bits_sent;
   logic [ID_WIDTH-1:0]           grant_id;
   logic                          busy;
   logic                          timeout_err;

   modport master (
      output req_valid,
      output req_data,
      output tx_busy,
      output tx_all_bits_sent,
      input  req_ack,
      input  req_done,
      input  tx_data,
      input  tx_start,
      input  grant_id,
      input  busy,
      input  timeout_err
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  tx_busy,
      input  tx_all_bits_sent,
      output req_ack,
      output req_done,
      output tx_data,
      output tx_start,
      output grant_id,
      output busy,
      output timeout_err
   );

endinterface

// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one RS232 transmitter among NUM_REQ producers.
// Latches the winner's byte, pulses tx_start, waits for the frame, watchdog aborts.
module rs232_tx_arbiter #(
   parameter int          NUM_REQ       = 4,
   parameter int          DATA_WIDTH    = 8,
   parameter logic [15:0] TIMEOUT_COUNT = 16'd8192,
   parameter int          ID_WIDTH      = $clog2(NUM_REQ)
) (
   input logic               clk,
   input logic               reset,
   rs232_tx_arbiter_if.slave bus
);

   localparam int IW1 = ID_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE,
      RELEASE
   } state_t;

   state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
   logic [ID_WIDTH-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]    ack_q, ack_d;
   logic [NUM_REQ-1:0]    done_q, done_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  start_q, start_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;
   logic [15:0]           wd_q, wd_d;

   logic [ID_WIDTH-1:0]   win;
   logic [ID_WIDTH-1:0]   cand;
   logic                  found;
   logic [ID_WIDTH-1:0]   grant_inc;
   logic [DATA_WIDTH-1:0] win_data;
   logic [15:0]           wd_inc;
   logic                  wd_hit;

   // (p + k) mod NUM_REQ without a divider; k never exceeds NUM_REQ-1
   function automatic logic [ID_WIDTH-1:0] wrap_add(
      input logic [ID_WIDTH-1:0] p,
      input int                  k
   );
      logic [IW1-1:0] s;
      s = {1'b0, p} + IW1'(k);
      if (s >= IW1'(NUM_REQ)) begin
         s = s - IW1'(NUM_REQ);
      end
      return s[ID_WIDTH-1:0];
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(
      input logic [ID_WIDTH-1:0] i
   );
      logic [NUM_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Pick the first pending requester at or after the round-robin pointer
   always_comb begin
      win   = ptr_q;
      cand  = ptr_q;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = wrap_add(ptr_q, k);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Select the winning requester's byte from the flat data bus
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == ID_WIDTH'(i)) begin
            win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign grant_inc = wrap_add(grant_q, 1);
   assign wd_inc    = wd_q + 16'd1;
   assign wd_hit    = (wd_inc == TIMEOUT_COUNT - 16'd1);

   // Next-state and registered-output decode; completion beats the watchdog
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      data_d  = data_q;
      ack_d   = '0;
      done_d  = '0;
      start_d = 1'b0;
      err_d   = err_q;
      wd_d    = wd_q;
      unique case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               ack_d   = onehot(win);
               start_d = 1'b1;
               data_d  = win_data;
               grant_d = win;
               wd_d    = '0;
               state_d = WAIT_BUSY;
            end
         end
         WAIT_BUSY,
         WAIT_DONE: begin
            wd_d = wd_inc;
            if (bus.tx_all_bits_sent) begin
               done_d  = onehot(grant_q);
               state_d = RELEASE;
            end else if (wd_hit) begin
               err_d   = 1'b1;
               ptr_d   = grant_inc;
               state_d = IDLE;
            end else if (state_q == WAIT_BUSY && bus.tx_busy) begin
               state_d = WAIT_DONE;
            end
         end
         RELEASE: begin
            ptr_d   = grant_inc;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers, synchronous reset aborts any frame
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
         ack_q   <= '0;
         done_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
      end
   end

   assign bus.req_ack     = ack_q;
   assign bus.req_done    = done_q;
   assign bus.tx_data     = data_q;
   assign bus.tx_start    = start_q;
   assign bus.grant_id    = grant_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = err_q;

endmodule
